// File: rtl/trig_func_sweeper.sv
// trig_func_sweeper: steps {a,b,c,d} through 16 minterms and captures y into truth; TRIG_SWEEP_ONES_EN adds the ones counter.
module trig_func_sweeper #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  flag_in,
  input  logic        y,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic [4:0]  flag,
  output logic        busy,
  output logic        done,
`ifdef TRIG_SWEEP_ONES_EN
  output logic [4:0]  ones,
`endif
  output logic [15:0] truth
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  localparam logic [3:0] LAST = 4'(SETTLE - 1);
  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("trig_func_sweeper: SETTLE must be in 1..15");
  end
  state_t state, nxt;
  logic [3:0] idx, cnt;
  logic [4:0] flag_q;
  wire accept = state == IDLE && start;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE   ? (start ? DRIVE : IDLE) :
          state == DRIVE  ? (cnt == LAST ? SAMPLE : DRIVE) :
          state == SAMPLE ? (idx == 4'hf ? DONE : DRIVE) : IDLE;
  always_comb begin
    busy = state == DRIVE || state == SAMPLE;
    done = state == DONE;
    {a, b, c, d} = busy ? idx : 4'h0;
    flag = busy ? flag_q : 5'h00;
  end
  always_ff @(posedge clk)
    if (rst) begin
      idx <= '0;
      cnt <= '0;
      flag_q <= '0;
      truth <= '0;
    end else if (accept) begin
      idx <= '0;
      cnt <= '0;
      flag_q <= flag_in;
      truth <= '0;
    end else if (state == DRIVE) begin
      cnt <= cnt + 4'h1;
    end else if (state == SAMPLE) begin
      truth[idx] <= y;
      cnt <= '0;
      idx <= idx == 4'hf ? idx : idx + 4'h1;
    end
`ifdef TRIG_SWEEP_ONES_EN
  always_ff @(posedge clk)
    if (rst || accept) ones <= '0;
    else if (state == SAMPLE && y === 1'b1) ones <= ones + 5'h1;
`endif
endmodule

// File: tb/tb_trig_func_sweeper.sv
// tb_trig_func_sweeper: two sweepers (SETTLE 1 and 3) checked per cycle against a queued truth-table model.
module tb_trig_func_sweeper;
  logic clk = 0, rst = 1, start = 0;
  logic [4:0] flag_in = 0;
  logic a[2], b[2], c[2], d[2], busy[2], done[2], y[2];
  logic [4:0] flag[2], ones[2];
  logic [15:0] truth[2];
  int mode = 0, cyc = 0, total = 0, bad = 0;
  logic [15:0] rtab = 0;
  typedef struct {int e; logic [4:0] f; logic [15:0] t; int o;} exp_t;
  exp_t q[2][$];
  logic [15:0] last_t[2] = '{16'h0, 16'h0};
  int last_o[2] = '{0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 2; k++) begin : g
    assign y[k] = mode == 0 ? d[k] : mode == 1 ? a[k] & b[k] : mode == 2 ? 1'b1 :
                  mode == 3 ? 1'b0 : rtab[{a[k], b[k], c[k], d[k]}];
`ifndef TRIG_SWEEP_ONES_EN
    assign ones[k] = '0;
`endif
    trig_func_sweeper #(.SETTLE(k ? 3 : 1)) u (
      .clk(clk), .rst(rst), .start(start), .flag_in(flag_in), .y(y[k]),
      .a(a[k]), .b(b[k]), .c(c[k]), .d(d[k]), .flag(flag[k]),
      .busy(busy[k]), .done(done[k]),
`ifdef TRIG_SWEEP_ONES_EN
      .ones(ones[k]),
`endif
      .truth(truth[k]));
  end

  function automatic logic [15:0] model(int m);
    logic [15:0] t;
    logic [3:0] v;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      t[i] = m == 0 ? v[0] : m == 1 ? v[3] & v[2] : m == 2 ? 1'b1 : m == 3 ? 1'b0 : rtab[i];
    end
    return t;
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s dut%0d got=%h want=%h cyc=%0d", nm, k, act, want, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    int s, len, rel;
    if (!rst)
      for (int k = 0; k < 2; k++) begin
        s = k ? 3 : 1;
        len = 16 * (s + 1);
        if (q[k].size() > 0 && cyc >= q[k][0].e) begin
          rel = cyc - q[k][0].e;
          if (rel < len) begin
            chk("busy", k, busy[k], 1);
            chk("done", k, done[k], 0);
            chk("abcd", k, {a[k], b[k], c[k], d[k]}, rel / (s + 1));
            chk("flag", k, flag[k], q[k][0].f);
            if (rel == 0) chk("truth_clr", k, truth[k], 0);
          end else begin
            chk("done", k, done[k], 1);
            chk("busy", k, busy[k], 0);
            chk("abcd", k, {a[k], b[k], c[k], d[k]}, 0);
            chk("flag", k, flag[k], 0);
            chk("truth", k, truth[k], q[k][0].t);
`ifdef TRIG_SWEEP_ONES_EN
            chk("ones", k, ones[k], q[k][0].o);
`endif
            last_t[k] = q[k][0].t;
            last_o[k] = q[k][0].o;
            void'(q[k].pop_front());
          end
        end else begin
          chk("idle_busy", k, busy[k], 0);
          chk("idle_done", k, done[k], 0);
          chk("idle_abcd", k, {a[k], b[k], c[k], d[k]}, 0);
          chk("idle_flag", k, flag[k], 0);
          chk("idle_truth", k, truth[k], last_t[k]);
`ifdef TRIG_SWEEP_ONES_EN
          chk("idle_ones", k, ones[k], last_o[k]);
`endif
        end
      end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(int k, int e, logic [4:0] f);
    exp_t x;
    x.e = e;
    x.f = f;
    x.t = model(mode);
    x.o = $countones(x.t);
    q[k].push_back(x);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL timeout waiting for done cyc=%0d", cyc);
      q[0].delete();
      q[1].delete();
    end
  endtask

  task automatic sweep(int m, logic [4:0] f, int hold);
    int e, len;
    mode = m;
    flag_in = f;
    start = 1;
    e = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      len = 16 * ((k ? 3 : 1) + 1);
      for (int x = e; x <= e + hold - 1; x += len + 2) push(k, x, f);
    end
    for (int i = 0; i < hold; i++) tick();
    start = 0;
    if (hold == 1) flag_in = 5'($urandom);
    wait_idle();
  endtask

  initial begin
    int e;
    repeat (3) tick();
    rst = 0;
    tick();
    sweep(0, 5'b11001, 1);
    chk("plan_aaaa", 0, truth[0], 16'haaaa);
    chk("plan_aaaa", 1, truth[1], 16'haaaa);
`ifdef TRIG_SWEEP_ONES_EN
    chk("plan_ones8", 0, ones[0], 8);
`endif
    sweep(1, 5'($urandom), 1);
    chk("plan_f000", 1, truth[1], 16'hf000);
`ifdef TRIG_SWEEP_ONES_EN
    chk("plan_ones4", 1, ones[1], 4);
`endif
    mode = 0;
    flag_in = 5'($urandom);
    start = 1;
    e = cyc + 1;
    push(0, e, flag_in);
    push(1, e, flag_in);
    tick();
    start = 0;
    while (cyc < e + 14) tick();
    rst = 1;
    q[0].delete();
    q[1].delete();
    last_t = '{16'h0, 16'h0};
    last_o = '{0, 0};
    tick();
    rst = 0;
    tick();
    sweep(0, 5'b10110, 1);
    sweep(2, 5'b01011, 80);
    chk("plan_ffff", 0, truth[0], 16'hffff);
    sweep(3, 5'b00000, 1);
    chk("plan_0000", 0, truth[0], 16'h0000);
    repeat (8) begin
      rtab = 16'($urandom);
      sweep(4, 5'($urandom), $urandom_range(1, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
